// File: rtl/vc_crossbar3_arb_ctrl.sv
// Round-robin val/rdy arbiter and TrustZone request filter driving the sel0..sel2 inputs of a 3x3 crossbar.
// Optional feature macro VC_XBAR_DENY_COUNT_EN enables a saturating denied-request counter on deny_count.
module vc_crossbar3_arb_ctrl #(
  parameter logic [2:0] p_secure_mask = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in0_val,
  input  logic       in1_val,
  input  logic       in2_val,
  output logic       in0_rdy,
  output logic       in1_rdy,
  output logic       in2_rdy,
  input  logic [1:0] in0_dest,
  input  logic [1:0] in1_dest,
  input  logic [1:0] in2_dest,
  input  logic       in0_domain,
  input  logic       in1_domain,
  input  logic       in2_domain,
  output logic [1:0] sel0,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  output logic       out0_val,
  output logic       out1_val,
  output logic       out2_val,
  input  logic       out0_rdy,
  input  logic       out1_rdy,
  input  logic       out2_rdy,
  output logic [2:0] deny_val,
  output logic [7:0] deny_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Destination 3 has no output; padding the mask with 0 keeps the lookup in range.
  localparam logic [3:0] MaskExt = {1'b0, p_secure_mask};

  logic [2:0] in_val;
  logic [2:0] in_dom;
  logic [2:0] out_rdy;
  logic [1:0] in_dest [3];
  logic [2:0] denied;
  logic [2:0] gnt_rdy;
  logic [2:0] out_busy;
  logic [5:0] sel_flat;
  logic [8:0] gnt_rdy_flat;
  logic [2:0] deny_val_q;

  assign in_val     = {in2_val, in1_val, in0_val};
  assign in_dom     = {in2_domain, in1_domain, in0_domain};
  assign out_rdy    = {out2_rdy, out1_rdy, out0_rdy};
  assign in_dest[0] = in0_dest;
  assign in_dest[1] = in1_dest;
  assign in_dest[2] = in2_dest;

  for (genvar gi = 0; gi < 3; gi++) begin : g_deny
    assign denied[gi] = in_val[gi] &
                        ((in_dest[gi] == 2'd3) | (MaskExt[in_dest[gi]] & ~in_dom[gi]));
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_out
    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand1, cand2, win;
    logic [2:0] elig;

    assign elig = in_val & ~denied & {in_dest[2] == 2'(gi), in_dest[1] == 2'(gi),
                                      in_dest[0] == 2'(gi)};
    assign cand1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    assign cand2 = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;

    always_comb begin
      win = ptr_q;
      if (elig[ptr_q])      win = ptr_q;
      else if (elig[cand1]) win = cand1;
      else if (elig[cand2]) win = cand2;
    end

    always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      case (state_q)
        IDLE: begin
          if (|elig) begin
            state_d = BUSY;
            sel_d   = win;
          end
        end
        BUSY: begin
          if (out_rdy[gi]) begin
            state_d = IDLE;
            ptr_d   = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        sel_q   <= 2'd0;
        ptr_q   <= 2'd0;
      end else begin
        state_q <= state_d;
        sel_q   <= sel_d;
        ptr_q   <= ptr_d;
      end
    end

    // sel_q doubles as the grant index while BUSY.
    assign out_busy[gi]           = (state_q == BUSY);
    assign sel_flat[2*gi +: 2]    = sel_q;
    assign gnt_rdy_flat[3*gi +: 3] = ((state_q == BUSY) && out_rdy[gi]) ? (3'b001 << sel_q) : 3'b000;
  end

  assign gnt_rdy = gnt_rdy_flat[2:0] | gnt_rdy_flat[5:3] | gnt_rdy_flat[8:6];
  assign {in2_rdy, in1_rdy, in0_rdy} = (denied | gnt_rdy) & {3{reset}};

  assign out0_val = out_busy[0];
  assign out1_val = out_busy[1];
  assign out2_val = out_busy[2];
  assign sel0     = sel_flat[1:0];
  assign sel1     = sel_flat[3:2];
  assign sel2     = sel_flat[5:4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) deny_val_q <= 3'b000;
    else        deny_val_q <= denied;
  end
  assign deny_val = deny_val_q;

`ifdef VC_XBAR_DENY_COUNT_EN
  logic [7:0] deny_cnt_q, deny_cnt_d;
  logic [8:0] cnt_sum;

  always_comb begin
    cnt_sum    = {1'b0, deny_cnt_q} + 9'(deny_val_q[0]) + 9'(deny_val_q[1]) + 9'(deny_val_q[2]);
    deny_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) deny_cnt_q <= 8'd0;
    else        deny_cnt_q <= deny_cnt_d;
  end
  assign deny_count = deny_cnt_q;
`else
  assign deny_count = 8'd0;
`endif

endmodule

// File: tb/tb_vc_crossbar3_arb_ctrl.sv
// Directed bench for vc_crossbar3_arb_ctrl: a per-cycle reference model plus hand-computed literal checks.
module tb_vc_crossbar3_arb_ctrl;
  localparam logic [2:0] MASK = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] iv = 3'b000, idom = 3'b000, ordy = 3'b000;
  logic [1:0] idest [3];
  logic       in0_rdy, in1_rdy, in2_rdy, out0_val, out1_val, out2_val;
  logic [1:0] sel0, sel1, sel2;
  logic [2:0] deny_val;
  logic [7:0] deny_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-output busy flag, granted input, round-robin pointer.
  int         mb [3];
  int         ms [3];
  int         mp [3];
  logic [2:0] mdeny = 3'b000;
  int         mcnt = 0;

  always #5 clk = ~clk;

  vc_crossbar3_arb_ctrl #(.p_secure_mask(MASK)) dut (
    .clk(clk), .reset(rst_n),
    .in0_val(iv[0]), .in1_val(iv[1]), .in2_val(iv[2]),
    .in0_rdy(in0_rdy), .in1_rdy(in1_rdy), .in2_rdy(in2_rdy),
    .in0_dest(idest[0]), .in1_dest(idest[1]), .in2_dest(idest[2]),
    .in0_domain(idom[0]), .in1_domain(idom[1]), .in2_domain(idom[2]),
    .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .out0_val(out0_val), .out1_val(out1_val), .out2_val(out2_val),
    .out0_rdy(ordy[0]), .out1_rdy(ordy[1]), .out2_rdy(ordy[2]),
    .deny_val(deny_val), .deny_count(deny_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit m_deny(input int i);
    logic [2:0] m;
    m = MASK;
    if (!iv[i]) return 1'b0;
    if (idest[i] == 2'd3) return 1'b1;
    return m[idest[i]] && !idom[i];
  endfunction

  function automatic bit m_elig(input int i, input int j);
    return iv[i] && !m_deny(i) && (int'(idest[i]) == j);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 3; j++) begin
        mb[j] <= 0; ms[j] <= 0; mp[j] <= 0;
      end
      mdeny <= 3'b000;
      mcnt  <= 0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        int w;
        w = -1;
        if (mb[j] != 0) begin
          if (ordy[j]) begin
            mb[j] <= 0;
            mp[j] <= (ms[j] + 1) % 3;
          end
        end else begin
          for (int k = 2; k >= 0; k--) begin
            if (m_elig((mp[j] + k) % 3, j)) w = (mp[j] + k) % 3;
          end
          if (w >= 0) begin
            mb[j] <= 1;
            ms[j] <= w;
          end
        end
      end
      for (int i = 0; i < 3; i++) mdeny[i] <= m_deny(i);
`ifdef VC_XBAR_DENY_COUNT_EN
      mcnt <= (mcnt + $countones(mdeny) > 255) ? 255 : mcnt + $countones(mdeny);
`endif
    end
  end

  always @(negedge clk) begin
    logic [2:0] er;
    er = 3'b000;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        er[i] = m_deny(i);
        for (int j = 0; j < 3; j++)
          if (mb[j] != 0 && ms[j] == i && ordy[j]) er[i] = 1'b1;
      end
    end
    chk("model_rdy", {in2_rdy, in1_rdy, in0_rdy}, er);
    chk("model_out_val", {out2_val, out1_val, out0_val}, {mb[2] != 0, mb[1] != 0, mb[0] != 0});
    chk("model_sel", {sel2, sel1, sel0}, (ms[2] << 4) | (ms[1] << 2) | ms[0]);
    chk("model_deny_val", deny_val, mdeny);
    chk("model_deny_count", deny_count, mcnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idest[0] = 2'd0; idest[1] = 2'd0; idest[2] = 2'd0;
    tick();
    chk("reset_out_val", {out2_val, out1_val, out0_val}, 0);
    chk("reset_sel", {sel2, sel1, sel0}, 0);
    chk("reset_deny", deny_val, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single transfer in1 -> out2
    ordy = 3'b100; iv[1] = 1'b1; idest[1] = 2'd2; idom[1] = 1'b0;
    #1 chk("single_rdy_idle", in1_rdy, 0);
    tick();
    chk("single_out2_val", out2_val, 1);
    chk("single_sel2", sel2, 1);
    chk("single_in1_rdy", in1_rdy, 1);
    iv[1] = 1'b0;
    tick();
    chk("single_out2_idle", out2_val, 0);

    // Round-robin on out0: grants 0,1,2,0 on cycles 1,3,5,7
    ordy = 3'b001; iv = 3'b111; idom = 3'b111;
    idest[0] = 2'd0; idest[1] = 2'd0; idest[2] = 2'd0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("rr_out0_val", out0_val, c % 2);
      if (c % 2 == 1) chk("rr_sel0", sel0, ((c - 1) / 2) % 3);
    end
    iv = 3'b000;
    tick();

    // Backpressure: in2 -> out1, held four cycles
    ordy = 3'b000; iv[2] = 1'b1; idest[2] = 2'd1; idom[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("bp_out1_val", out1_val, 1);
      chk("bp_sel1", sel1, 2);
      chk("bp_in2_rdy", in2_rdy, 0);
    end
    ordy[1] = 1'b1;
    #1 chk("bp_in2_rdy_release", in2_rdy, 1);
    tick();
    iv[2] = 1'b0;
    chk("bp_out1_idle", out1_val, 0);

    // Security deny: non-secure in0 to secure out0 dropped, secure in1 granted
    ordy = 3'b001; iv = 3'b011;
    idest[0] = 2'd0; idom[0] = 1'b0; idest[1] = 2'd0; idom[1] = 1'b1;
    #1 chk("sec_in0_rdy", in0_rdy, 1);
    chk("sec_in1_rdy_idle", in1_rdy, 0);
    tick();
    iv[0] = 1'b0;
    chk("sec_deny_val", deny_val, 3'b001);
    chk("sec_sel0", sel0, 1);
    chk("sec_out0_val", out0_val, 1);
    tick();
    iv[1] = 1'b0;
    chk("sec_deny_clear", deny_val, 0);
`ifdef VC_XBAR_DENY_COUNT_EN
    chk("sec_deny_count", deny_count, 1);
`else
    chk("sec_deny_count", deny_count, 0);
`endif
    tick();

    // Invalid destination
    iv[2] = 1'b1; idest[2] = 2'd3; idom[2] = 1'b1;
    #1 chk("inv_in2_rdy", in2_rdy, 1);
    tick();
    iv[2] = 1'b0;
    chk("inv_deny_val", deny_val, 3'b100);
    chk("inv_out_val", {out2_val, out1_val, out0_val}, 0);
    tick();
`ifdef VC_XBAR_DENY_COUNT_EN
    chk("inv_deny_count", deny_count, 2);
`endif

    // Asynchronous reset while out0 is BUSY
    ordy = 3'b000; iv[1] = 1'b1; idest[1] = 2'd0; idom[1] = 1'b1;
    tick();
    chk("ar_out0_busy", out0_val, 1);
    chk("ar_sel0_busy", sel0, 1);
    #1;
    iv[2] = 1'b1; idest[2] = 2'd3; ordy[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("ar_out0_val", out0_val, 0);
    chk("ar_sel0", sel0, 0);
    chk("ar_rdy", {in2_rdy, in1_rdy, in0_rdy}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    iv[2] = 1'b0;
    chk("ar_regrant_val", out0_val, 1);
    chk("ar_regrant_sel", sel0, 1);
    chk("ar_regrant_rdy", in1_rdy, 1);
    iv[1] = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vc_crossbar3_arb_ctrl.md
Name: vc_crossbar3_arb_ctrl

Overview:
- Control stage directly upstream of the 3x3 secure crossbar.
- Arbitrates val/rdy requests from three input ports to three output ports and drives the crossbar's sel0..sel2, holding each select stable for the whole output handshake.
- Enforces the TrustZone policy: non-secure requests to secure-only outputs, or to an invalid destination, are consumed and dropped, and the drop is reported.
- The crossbar's data and domain paths stay combinational; this block owns all sequencing.

Parameters:
- p_secure_mask, 3'b000: bit j=1 makes output j secure-only.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; asserting it clears all state immediately.
- in0_val, in1_val, in2_val  input  1 each  request valid.
- in0_rdy, in1_rdy, in2_rdy  output  1 each  request consumed this cycle.
- in0_dest, in1_dest, in2_dest  input  2 each  target output 0..2; 3 is invalid.
- in0_domain, in1_domain, in2_domain  input  1 each  1 = secure, 0 = non-secure.
- sel0, sel1, sel2  output  2 each  crossbar select per output, registered.
- out0_val, out1_val, out2_val  output  1 each  output valid, registered.
- out0_rdy, out1_rdy, out2_rdy  input  1 each  downstream ready.
- deny_val  output  3  registered per-input drop pulse.
- deny_count  output  8  denied-request count (see Optional Feature).

Behaviour:
- Input protocol: once inN_val is high, dest and domain stay stable until inN_rdy is seen.
- Reset values: sel*=0, out*_val=0, deny_val=0, deny_count=0, all RR pointers=0, all output FSMs IDLE. All in*_rdy are therefore 0 combinationally during reset.
- Request classes per input i in a cycle with in_val:
  - Denied if dest==3, or (p_secure_mask[dest]==1 and domain==0).
  - Otherwise eligible for output dest.
- Denied request handling:
  - in_rdy[i]=1 combinationally that cycle; the request is dropped.
  - deny_val[i]=1 the next cycle for exactly one cycle.
  - Multiple simultaneous denials each set their own bit.
  - Denial never touches any output FSM, sel, or pointer.
- Per-output FSM, independent for j=0..2:
  - IDLE: out_val_j=0. If any eligible input targets j, the round-robin winner is the first eligible index at or after ptr_j, in order ptr, ptr+1, ptr+2 mod 3. On the clock edge: sel_j <= winner, gnt_j <= winner, out_val_j <= 1, state <= BUSY. No input rdy is asserted in IDLE.
  - BUSY: out_val_j=1 and sel_j is held. in_rdy[gnt_j] = out_rdy_j, combinationally.
  - BUSY handshake (out_val_j & out_rdy_j): the input is consumed the same cycle, ptr_j <= (gnt_j+1) mod 3, out_val_j <= 0, state <= IDLE.
  - BUSY, no handshake: hold everything.
- Throughput: one transfer per 2 cycles per output. Request-to-out_val latency is 1 cycle.
- An input targets exactly one output, so it can never be granted twice. in_rdy is the OR of its deny term and its grant term; the two are mutually exclusive because a denied request is never eligible.
- sel_j keeps its last value in IDLE; it changes only on a grant.
- Reset mid-transfer: the FSM aborts to IDLE. The upstream request stays pending and is re-arbitrated after reset deasserts.

Optional Feature:
- Macro: VC_XBAR_DENY_COUNT_EN.
- Defined: deny_count increments on every cycle with any deny_val bit set.
  - Increment amount is popcount(deny_val), i.e. +1, +2 or +3.
  - Saturates at 255; cleared only by reset.
- Undefined: no counter logic; deny_count is tied to 8'd0.
- Arbitration and deny_val behaviour are identical either way.

Test Plan:
- Single transfer: in1 val, dest=2, domain=0, mask=0, out2_rdy=1. Expect out2_val=1 and sel2=1 next cycle, in1_rdy=1 in that cycle, out2_val=0 the following cycle.
- Round-robin: in0, in1, in2 all dest=0, out0_rdy=1 throughout. Expect grant order 0,1,2,0 on cycles 1,3,5,7 with sel0 = 0,1,2,0.
- Backpressure: grant in2 to out1, out1_rdy=0 for 4 cycles. Expect out1_val=1, sel1=2, in2_rdy=0 held all 4 cycles; rdy=1 then transfers and returns IDLE.
- Security deny: mask=3'b001; in0 dest=0 domain=0 and in1 dest=0 domain=1 same cycle. Expect in0_rdy=1 immediately, deny_val=3'b001 next cycle, in1 granted (sel0=1); with VC_XBAR_DENY_COUNT_EN, deny_count=1.
- Invalid dest: in2 dest=3. Expect in2_rdy=1, deny_val=3'b100 next cycle, no out*_val change.
- Async reset mid-BUSY: drop reset while out0_val=1. Expect out0_val=0, sel0=0, in*_rdy=0 immediately without a clock edge; pending request regranted one cycle after release.
